seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial bit-pattern detector: the next-generation replacement for the fixed 101 Moore/Mealy detectors. It takes a serial bit stream and flags every occurrence of a compile-time pattern of any length N ≥ 2. Overlapping or non-overlapping matching and Moore or Mealy output timing are selectable by parameter. A saturating match counter is included. It sits directly on the serial input path and drives single-cycle match pulses to downstream control logic.

## Interface
- N, 3: pattern length in bits; legal range 2..32.
- PATTERN, 3'b101 (N bits): pattern to detect. Bit N-1 is the oldest bit received; bit 0 is the newest.
- OVERLAP, 1: 1 = the bits of a match may start the next match; 0 = detection restarts cleanly after each match.
- MEALY, 0: 0 = registered (Moore) output; 1 = combinational (Mealy) output.
- COUNT_W, 8: width of the match counter.
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- x, input, 1: serial data bit.
- x_valid, input, 1: x is sampled only when high. Cycles with x_valid low are bubbles that change no state.
- clear_count, input, 1: synchronous clear of match_count.
- y, output, 1: match pulse.
- match_count, output, COUNT_W: number of matches since reset or the last clear; saturates at all-ones.

## Operation
- State:
  - hist[N-1:0]: last N accepted bits, newest in the LSB.
  - fill: number of bits accepted since reset or since the last non-overlap match; saturates at N-1 (width $clog2(N)+1).
  - y_q: registered match flag.
  - match_count.
- Definitions:
  - cand = {hist[N-2:0], x}
  - hit = x_valid & (fill == N-1) & (cand == PATTERN)
- fill == N-1 is required before any hit can occur. There are no false matches against reset-zero history (e.g. PATTERN 000 straight after reset).
- On each clock edge with x_valid = 1:
  - hist ← cand
  - fill ← 0 if hit and OVERLAP = 0; otherwise min(fill+1, N-1)
- On each clock edge with x_valid = 0: hist and fill hold.
- y_q ← hit on every cycle, including bubble cycles, where it loads 0.
- y = y_q when MEALY = 0; y = hit & ~reset when MEALY = 1.
- match_count, in priority order:
  - clear_count = 1 → 0 (clear wins over a simultaneous hit).
  - else hit and match_count not all-ones → match_count + 1.
  - else hold.
- Reset (any cycle, including mid-pattern): hist = 0, fill = 0, y_q = 0, match_count = 0. A partially received pattern is discarded. In Mealy mode y is forced 0 while reset is high.

## Timing
- Mealy: y rises in the same cycle that the completing bit is presented with x_valid high; zero latency.
- Moore: y is high for exactly one cycle, the cycle after the completing bit is accepted; one-cycle latency.
- match_count reflects a hit one cycle after the completing bit, in both modes.
- y is never high for more than one consecutive cycle per match. Back-to-back overlapping matches produce consecutive single-cycle pulses.
- After reset deasserts, the first possible hit is on the N-th accepted bit.

## Structure
- Shared package seq_det_pkg holds:
  - the default pattern constant DEF_PATTERN_101;
  - the mode constants MODE_MOORE = 0 and MODE_MEALY = 1.
- Sub-module sat_counter (parameter W; ports clk, reset, clr, inc, q) implements match_count. It is reused by later counters in the same design.
- The history/fill logic and output muxing stay in the top module. The pattern comparator is a single N-bit equality; no per-pattern state encoding is used.

## Test plan
- N=3, PATTERN=101, OVERLAP=1, MEALY=0; stream 0,1,0,1,0,1, all valid → y pulses one cycle after bit 4 and after bit 6; match_count = 2.
- Same stream with OVERLAP=0 → single y pulse after bit 4, no pulse for bit 6; match_count = 1.
- MEALY=1, stream 1,0,1 → y high combinationally in the cycle bit 3 is presented. Insert two x_valid=0 bubbles between bits 2 and 3 → no pulse during the bubbles; pulse still occurs on bit 3.
- PATTERN=000 straight after reset, stream 0,0,0 → no y on bits 1 and 2, y on bit 3 only. Assert reset after bit 2 of a second 0,0,0 → no match on the following bit.
- COUNT_W=2, six overlapping 101 matches → match_count saturates at 3. clear_count asserted in the same cycle as a hit → match_count = 0 on the next cycle.
- N=8, PATTERN=8'hA5, MEALY=0, random 1000-bit stream with x_valid randomly low about 30% of the time → y and match_count agree with a reference model for both OVERLAP values.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the serial pattern detectors.
// Default pattern and output-timing mode selectors.
package seq_det_pkg;
    localparam logic [2:0] DEF_PATTERN_101 = 3'b101;
    localparam bit MODE_MOORE = 1'b0;
    localparam bit MODE_MEALY = 1'b1;
endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear takes priority over increment; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with overlap/Mealy options
// and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned   N       = 3,
    parameter logic [N-1:0]  PATTERN = N'(DEF_PATTERN_101),
    parameter bit            OVERLAP = 1'b1,
    parameter bit            MEALY   = MODE_MOORE,
    parameter int            COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               clear_count,
    output logic               y,
    output logic [COUNT_W-1:0] match_count
);
    localparam int FW = $clog2(N) + 1;
    localparam logic [FW-1:0] FULL = FW'(N - 1);

    logic [N-1:0]  hist;
    logic [N-1:0]  cand;
    logic [FW-1:0] fill;
    logic          y_q;
    logic          hit;

    assign cand = {hist[N-2:0], x};
    // fill gate keeps reset-zero history from matching all-zero patterns
    assign hit  = x_valid && (fill == FULL) && (cand == PATTERN);

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
            y_q  <= 1'b0;
        end else begin
            y_q <= hit;
            if (x_valid) begin
                hist <= cand;
                if (hit && !OVERLAP) begin
                    fill <= '0;
                end else if (fill != FULL) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    assign y = (MEALY == MODE_MEALY) ? (hit & ~reset) : y_q;

    sat_counter #(
        .W(COUNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clear_count),
        .inc  (hit),
        .q    (match_count)
    );
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table plus randomised reference-model check
// for seq_detector_param in several configurations.
module tb_seq_detector_param;
    logic clk = 1'b0;
    logic reset, x, x_valid, clear_count;
    logic y0, y1, y2, y3, y4, y5, y6;
    logic [7:0] mc0, mc1, mc2, mc3, mc5, mc6;
    logic [1:0] mc4;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // 101 overlap Moore
    seq_detector_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1),
        .MEALY(1'b0), .COUNT_W(8)) d0 (.clk(clk), .reset(reset),
        .x(x), .x_valid(x_valid), .clear_count(clear_count),
        .y(y0), .match_count(mc0));
    // 101 non-overlap Moore
    seq_detector_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0),
        .MEALY(1'b0), .COUNT_W(8)) d1 (.clk(clk), .reset(reset),
        .x(x), .x_valid(x_valid), .clear_count(clear_count),
        .y(y1), .match_count(mc1));
    // 101 overlap Mealy
    seq_detector_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1),
        .MEALY(1'b1), .COUNT_W(8)) d2 (.clk(clk), .reset(reset),
        .x(x), .x_valid(x_valid), .clear_count(clear_count),
        .y(y2), .match_count(mc2));
    // 000 non-overlap Mealy
    seq_detector_param #(.N(3), .PATTERN(3'b000), .OVERLAP(1'b0),
        .MEALY(1'b1), .COUNT_W(8)) d3 (.clk(clk), .reset(reset),
        .x(x), .x_valid(x_valid), .clear_count(clear_count),
        .y(y3), .match_count(mc3));
    // 101 overlap Moore, 2-bit counter
    seq_detector_param #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1),
        .MEALY(1'b0), .COUNT_W(2)) d4 (.clk(clk), .reset(reset),
        .x(x), .x_valid(x_valid), .clear_count(clear_count),
        .y(y4), .match_count(mc4));
    // A5 overlap / non-overlap Moore
    seq_detector_param #(.N(8), .PATTERN(8'hA5), .OVERLAP(1'b1),
        .MEALY(1'b0), .COUNT_W(8)) d5 (.clk(clk), .reset(reset),
        .x(x), .x_valid(x_valid), .clear_count(clear_count),
        .y(y5), .match_count(mc5));
    seq_detector_param #(.N(8), .PATTERN(8'hA5), .OVERLAP(1'b0),
        .MEALY(1'b0), .COUNT_W(8)) d6 (.clk(clk), .reset(reset),
        .x(x), .x_valid(x_valid), .clear_count(clear_count),
        .y(y6), .match_count(mc6));

    typedef struct {
        bit rst, v, xb, clr;
        bit y0, y1, y2, y3;
        int c0, c1, c4;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h",
                     name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit b,
                         input bit c);
        reset = r;
        x_valid = v;
        x = b;
        clear_count = c;
    endtask

    // reference model state for the A5 detectors
    bit [7:0] win5, win6;
    int since5, since6, cnt5, cnt6;
    bit hit5, hit6;
    bit q[$];

    initial begin
        //          rst v x clr  y0 y1 y2 y3  c0 c1 c4
        tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0,  1, 1, 1, 0,  1, 1, 1};
        tbl[5]  = '{0, 1, 0, 0,  0, 0, 0, 0,  1, 1, 1};
        tbl[6]  = '{0, 1, 1, 0,  1, 0, 1, 0,  2, 1, 2};
        tbl[7]  = '{0, 0, 1, 0,  0, 0, 0, 0,  2, 1, 2};
        tbl[8]  = '{0, 1, 0, 0,  0, 0, 0, 0,  2, 1, 2};
        tbl[9]  = '{0, 0, 1, 0,  0, 0, 0, 0,  2, 1, 2};
        tbl[10] = '{0, 0, 1, 0,  0, 0, 0, 0,  2, 1, 2};
        tbl[11] = '{0, 1, 1, 0,  1, 1, 1, 0,  3, 2, 3};
        tbl[12] = '{0, 1, 0, 0,  0, 0, 0, 0,  3, 2, 3};
        tbl[13] = '{0, 1, 1, 0,  1, 0, 1, 0,  4, 2, 3};
        tbl[14] = '{0, 1, 0, 0,  0, 0, 0, 0,  4, 2, 3};
        tbl[15] = '{0, 1, 1, 1,  1, 1, 1, 0,  0, 0, 0};
        tbl[16] = '{1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[17] = '{0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[18] = '{0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[19] = '{0, 1, 0, 0,  0, 0, 0, 1,  0, 0, 0};
        tbl[20] = '{0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[21] = '{0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[22] = '{1, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[23] = '{0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[24] = '{0, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0};
        tbl[25] = '{0, 1, 0, 0,  0, 0, 0, 1,  0, 0, 0};

        drive(1, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].xb, tbl[i].clr);
            #1;
            chk("mealy101_y", i, {31'b0, y2}, {31'b0, tbl[i].y2});
            chk("mealy000_y", i, {31'b0, y3}, {31'b0, tbl[i].y3});
            @(posedge clk);
            #1;
            chk("moore_ov_y", i, {31'b0, y0}, {31'b0, tbl[i].y0});
            chk("moore_nov_y", i, {31'b0, y1}, {31'b0, tbl[i].y1});
            chk("moore_ov_cnt", i, {24'b0, mc0}, tbl[i].c0);
            chk("moore_nov_cnt", i, {24'b0, mc1}, tbl[i].c1);
            chk("sat2_cnt", i, {30'b0, mc4}, tbl[i].c4);
        end

        // random A5 stream against a reference model
        drive(1, 0, 0, 0);
        @(posedge clk);
        #1;
        win5 = '0; win6 = '0;
        since5 = 0; since6 = 0;
        cnt5 = 0; cnt6 = 0;
        for (int i = 0; i < 1000; i++) begin
            bit v, b;
            v = ($urandom_range(0, 9) >= 3);
            if (q.size() == 0) begin
                int r;
                r = $urandom_range(0, 7);
                if (r == 0) begin
                    for (int k = 7; k >= 0; k--) q.push_back(8'hA5 >> k);
                    if ($urandom_range(0, 1) == 1)
                        for (int k = 4; k >= 0; k--)
                            q.push_back(5'b00101 >> k);
                end else begin
                    q.push_back($urandom_range(0, 1) == 1);
                end
            end
            b = q[0];
            if (v) void'(q.pop_front());
            drive(0, v, b, 0);
            hit5 = v && since5 >= 7 && {win5[6:0], b} == 8'hA5;
            hit6 = v && since6 >= 7 && {win6[6:0], b} == 8'hA5;
            @(posedge clk);
            #1;
            if (v) begin
                win5 = {win5[6:0], b};
                win6 = {win6[6:0], b};
                since5++;
                since6 = hit6 ? 0 : since6 + 1;
            end
            if (hit5 && cnt5 < 255) cnt5++;
            if (hit6 && cnt6 < 255) cnt6++;
            chk("a5_ov_y", i, {31'b0, y5}, {31'b0, hit5});
            chk("a5_nov_y", i, {31'b0, y6}, {31'b0, hit6});
            chk("a5_ov_cnt", i, {24'b0, mc5}, cnt5);
            chk("a5_nov_cnt", i, {24'b0, mc6}, cnt6);
        end
        // the injected A5+00101 runs must have produced matches
        tests++;
        if (cnt5 == 0) begin
            fails++;
            $display("FAIL a5_any_hits: got %0d expected >0", cnt5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
